// File: rtl/d_write_buffer.sv
// d_write_buffer
//   Memory-side stage behind the write-through data cache. Stores are posted
//   into a small in-order FIFO and acknowledged in the same cycle. Buffered
//   writes drain one at a time over an SRAM-like bus (request/addr_ok/data_ok).
//   Reads are issued as single-word transfers only once the FIFO is empty.
//   This keeps a read from passing an older buffered write to the same address.
//
// Ports
//   clk, clrn                 clock, asynchronous active-low reset
//   c_strobe/c_rw/c_a         cache request: valid, 0=read 1=write, address
//   c_din/c_wen               write data and byte enables
//   c_dout/c_ready            read data and request-complete strobe to cache
//   bus_req/bus_wr/bus_size   bus request, direction, size (0=B, 1=H, 2=W)
//   bus_addr/bus_wdata        bus address and write data (0 when bus_req=0)
//   bus_addr_ok/bus_data_ok   bus address-phase accept, data-phase done
//   bus_rdata                 bus read data, valid with bus_data_ok
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus quiet; pick the next buffered write, otherwise a pending read
// W_ADDR  | FIFO head on the bus as a write request, waiting for addr_ok
// W_DATA  | write address accepted, waiting for data_ok, then pop the head
// R_ADDR  | latched read address on the bus (word), waiting for addr_ok
// R_DATA  | read address accepted, waiting for data_ok carrying bus_rdata
// R_RESP  | captured read word presented to the cache with c_ready

module d_write_buffer #(
    parameter int A_WIDTH    = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               c_strobe,
    input  logic               c_rw,
    input  logic [A_WIDTH-1:0] c_a,
    input  logic [31:0]        c_din,
    input  logic [3:0]         c_wen,
    output logic [31:0]        c_dout,
    output logic               c_ready,
    output logic               bus_req,
    output logic               bus_wr,
    output logic [1:0]         bus_size,
    output logic [A_WIDTH-1:0] bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [31:0]        bus_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_DATA = 3'd4,
        R_RESP = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [A_WIDTH-1:0]     fifo_addr_q [DEPTH];
    logic [A_WIDTH-1:0]     fifo_addr_d [DEPTH];
    logic [31:0]            fifo_data_q [DEPTH];
    logic [31:0]            fifo_data_d [DEPTH];
    logic [1:0]             fifo_size_q [DEPTH];
    logic [1:0]             fifo_size_d [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic [A_WIDTH-1:0]     rd_addr_q, rd_addr_d;
    logic [31:0]            c_dout_q, c_dout_d;

    logic                   wen_valid;
    logic [1:0]             entry_size;
    logic [1:0]             entry_low;
    logic                   fifo_full;
    logic                   write_accept;
    logic                   read_pending;
    logic                   push;
    logic                   pop;

    // Byte-enable pattern decides transfer size and the low address bits.
    // Patterns the bus cannot express are acknowledged but never posted.
    always_comb begin
        wen_valid  = 1'b1;
        entry_size = 2'd2;
        entry_low  = 2'b00;
        case (c_wen)
            4'b1111: begin entry_size = 2'd2; entry_low = 2'b00; end
            4'b1100: begin entry_size = 2'd1; entry_low = 2'b10; end
            4'b0011: begin entry_size = 2'd1; entry_low = 2'b00; end
            4'b1000: begin entry_size = 2'd0; entry_low = 2'b11; end
            4'b0100: begin entry_size = 2'd0; entry_low = 2'b10; end
            4'b0010: begin entry_size = 2'd0; entry_low = 2'b01; end
            4'b0001: begin entry_size = 2'd0; entry_low = 2'b00; end
            default: wen_valid = 1'b0;
        endcase
    end

    assign fifo_full    = (count_q == FULL_CNT);
    assign write_accept = c_strobe & c_rw & ~fifo_full;
    assign read_pending = c_strobe & ~c_rw;
    assign push         = write_accept & wen_valid;
    assign pop          = (state_q == W_DATA) & bus_data_ok;

    // Write ack is combinational so a store completes in its own cycle;
    // read ack comes only from the registered R_RESP state.
    assign c_ready = write_accept | ((state_q == R_RESP) & read_pending);
    assign c_dout  = c_dout_q;

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_size_d = fifo_size_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = {c_a[A_WIDTH-1:2], entry_low};
            fifo_data_d[wr_ptr_q] = c_din;
            fifo_size_d[wr_ptr_q] = entry_size;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        c_dout_d  = c_dout_q;
        case (state_q)
            IDLE: begin
                // A write being posted this cycle counts as buffered, so the
                // drain starts on the very next cycle.
                if ((count_q != '0) || push) begin
                    state_d = W_ADDR;
                end else if (read_pending) begin
                    state_d   = R_ADDR;
                    rd_addr_d = c_a;
                end
            end
            W_ADDR: if (bus_addr_ok) state_d = W_DATA;
            W_DATA: if (bus_data_ok) state_d = IDLE;
            R_ADDR: if (bus_addr_ok) state_d = R_DATA;
            R_DATA: begin
                if (bus_data_ok) begin
                    state_d  = R_RESP;
                    c_dout_d = bus_rdata;
                end
            end
            R_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state_q)
            W_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = 1'b1;
                bus_size  = fifo_size_q[rd_ptr_q];
                bus_addr  = fifo_addr_q[rd_ptr_q];
                bus_wdata = fifo_data_q[rd_ptr_q];
            end
            R_ADDR: begin
                bus_req  = 1'b1;
                bus_size = 2'd2;
                bus_addr = {rd_addr_q[A_WIDTH-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            c_dout_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_size_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_addr_q   <= rd_addr_d;
            c_dout_q    <= c_dout_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            fifo_size_q <= fifo_size_d;
        end
    end

endmodule

// File: doc/d_write_buffer.md
Name: d_write_buffer

Overview:
Memory-side stage placed directly downstream of the write-through data cache. It takes the cache's strobe/ready memory requests and posts writes into a small FIFO, so stores complete in one cycle. Writes drain in order, and reads go out as single-word transfers, over an SRAM-like request/addr_ok/data_ok bus toward the bus bridge. Reads never bypass buffered writes, which guarantees read-after-write ordering.

Parameters:
A_WIDTH, 32, address width
DEPTH_LOG2, 2, log2 of FIFO entries (default 4 entries)

Ports:
clk  in  1  clock
clrn  in  1  asynchronous active-low reset
c_strobe  in  1  request valid from cache (held until c_ready)
c_rw  in  1  0 = read, 1 = write
c_a  in  A_WIDTH  request address (already translated by cache)
c_din  in  32  write data
c_wen  in  4  byte enables for writes
c_dout  out  32  read data to cache
c_ready  out  1  request completed this cycle
bus_req  out  1  bus request
bus_wr  out  1  1 = write
bus_size  out  2  0 = byte, 1 = half, 2 = word
bus_addr  out  A_WIDTH  bus address
bus_wdata  out  32  bus write data
bus_addr_ok  in  1  address phase accepted (when bus_req=1)
bus_data_ok  in  1  data phase complete
bus_rdata  in  32  read data, valid with bus_data_ok

Behaviour:
- Reset (clrn=0, async): FIFO emptied (count=0, pointers 0), FSM=IDLE, c_ready=0, c_dout=0, bus_req=0. An in-flight bus transaction is abandoned; the bus side is reset by the same clrn.
- FIFO entry: {addr, wdata, size}. Size and address come from c_wen, and wdata passes through unchanged.
  - 1111 -> size 2, addr[1:0]=00
  - 1100 -> size 1, addr[1:0]=10
  - 0011 -> size 1, addr[1:0]=00
  - 1000/0100/0010/0001 -> size 0, addr[1:0]=11/10/01/00
  - Any other c_wen -> write acknowledged (c_ready=1) but not pushed.
- Write accept (combinational): c_strobe & c_rw & count<DEPTH -> c_ready=1 and push at the clock edge. When full, c_ready=0 and the cache holds the request.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Read: c_strobe & ~c_rw is pending. It is not issued until the FIFO is empty (count=0 and FSM in IDLE).
- FSM states IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA, R_RESP:
  - IDLE: count!=0 -> W_ADDR; else read pending -> R_ADDR (c_a latched); else stay. Writes take priority.
  - W_ADDR: bus_req=1, bus_wr=1, fields from FIFO head. On bus_addr_ok -> W_DATA.
  - W_DATA: bus_req=0. On bus_data_ok -> pop head, go to IDLE.
  - R_ADDR: bus_req=1, bus_wr=0, bus_size=2, bus_addr={latched addr[A_WIDTH-1:2],2'b00}. On bus_addr_ok -> R_DATA.
  - R_DATA: on bus_data_ok -> capture bus_rdata into c_dout, go to R_RESP.
  - R_RESP: c_ready=1 for exactly one cycle, c_dout holds the captured word, then IDLE.
- Read latency with zero bus wait states and an empty FIFO: 4 cycles from strobe to c_ready.
- Writes posted while a read is in R_* states are accepted into the FIFO and drain after the read.
- bus_data_ok is only sampled in W_DATA and R_DATA; elsewhere it is ignored.
- When bus_req=0, bus_wr, bus_size, bus_addr and bus_wdata are all driven to 0.
- c_dout holds its last captured value outside R_RESP.
- c_ready is 0 whenever c_strobe=0.

Test Plan:
- Reset: after clrn=0, bus_req=0, c_ready=0, c_dout=0, count=0. Deassert reset with no strobe -> bus stays idle.
- Single SW 0x1faf_0000, data 0xDEADBEEF, wen 1111 -> c_ready=1 the same cycle. Next cycle bus_req=1, bus_wr=1, size 2, addr 0x1faf_0000, wdata 0xDEADBEEF. addr_ok then data_ok -> FIFO empty.
- SB to 0x0000_1003, wen 1000 -> bus size 0, addr 0x0000_1003. SH with wen 0011 -> size 1, addr[1:0]=00.
- Five back-to-back SWs with bus_addr_ok held 0 -> first four get c_ready=1. Fifth gets c_ready=0 until the first pop, then is accepted. Bus order matches issue order.
- SW 0x100 = 0x11 followed by LW 0x100 -> write completes on the bus before any read request. Bus returns 0x11 -> c_dout=0x11 with a one-cycle c_ready in R_RESP.
- Assert clrn=0 while in R_DATA with two writes buffered -> immediately FSM IDLE, count 0, bus_req 0. No c_ready pulse after reset release.
